iter_alu_unit: RTL and testbench

- Multi-cycle execute unit for the extended ALU operations MUL, DIV and POW. It sits directly downstream of the instruction decoder and consumes its 3-bit ALUControl code.
- Single-cycle ops (ADD/SUB/AND/ORR) stay in the main ALU. This block handles the iterative ops and holds the datapath stalled through a busy signal.
- Results return to the writeback mux when done pulses.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/iter_mul.sv | 73 +++++++
 rtl/iter_alu_unit.sv | 231 +++++++++++++++++++++++
 tb/tb_iter_alu_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl op codes and the iterative-unit state type.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;
    localparam logic [2:0] ALU_DIV = 3'b101;
    localparam logic [2:0] ALU_POW = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_POW_STEP,
        ST_POW_MR,
        ST_POW_SQ,
        ST_FIN
    } alu_state_e;

endpackage

// File: rtl/iter_mul.sv
// WIDTH-bit shift-add multiplier, low-word product. Operands latched on mstart,
// mdone pulses exactly WIDTH cycles later with mprod valid.
module iter_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mstart,
    input  logic [WIDTH-1:0] ma,
    input  logic [WIDTH-1:0] mb,
    output logic             mdone,
    output logic [WIDTH-1:0] mprod
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             mdone_q, mdone_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        mdone_d  = 1'b0;
        if (mstart) begin
            mcand_d  = ma;
            mplier_d = mb;
            prod_d   = '0;
            cnt_d    = CW'(WIDTH);
            run_d    = 1'b1;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            // last iteration lands together with the done pulse
            if (cnt_q == CW'(1)) begin
                run_d   = 1'b0;
                mdone_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            mdone_q  <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            mdone_q  <= mdone_d;
        end
    end

    assign mdone = mdone_q;
    assign mprod = prod_q;

endmodule

// File: rtl/iter_alu_unit.sv
// Multi-cycle execute unit for MUL, DIV and POW. Holds busy while an op is in
// flight and pulses done with the result; inline restoring divider.
module iter_alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             illegal_op
);

    localparam int CW = $clog2(WIDTH + 1);

    alu_state_e       state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic             illegal_op_q, illegal_op_d;

    // acc: POW accumulator / DIV dividend-quotient shifter; base: POW base / divisor
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pend_dz_q, pend_dz_d;
    logic             pend_ill_q, pend_ill_d;

    logic             mstart;
    logic [WIDTH-1:0] mul_a, mul_b;
    logic             mdone;
    logic [WIDTH-1:0] mprod;
    logic [WIDTH:0]   div_r, div_diff;

    iter_mul #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .reset  (reset),
        .mstart (mstart),
        .ma     (mul_a),
        .mb     (mul_b),
        .mdone  (mdone),
        .mprod  (mprod)
    );

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        result_d      = result_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        illegal_op_d  = illegal_op_q;
        acc_d         = acc_q;
        base_d        = base_q;
        e_d           = e_q;
        part_d        = part_q;
        cnt_d         = cnt_q;
        pend_dz_d     = pend_dz_q;
        pend_ill_d    = pend_ill_q;
        mstart        = 1'b0;
        mul_a         = a;
        mul_b         = b;
        div_r         = {part_q, acc_q[WIDTH-1]};
        div_diff      = div_r - {1'b0, base_q};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d        = 1'b1;
                    result_d      = '0;
                    remainder_d   = '0;
                    div_by_zero_d = 1'b0;
                    illegal_op_d  = 1'b0;
                    pend_dz_d     = 1'b0;
                    pend_ill_d    = 1'b0;
                    part_d        = '0;
                    case (op)
                        ALU_MUL: begin
                            mstart  = 1'b1;
                            state_d = ST_MUL;
                        end
                        ALU_DIV: begin
                            if (b == '0) begin
                                acc_d     = '1;
                                part_d    = a;
                                pend_dz_d = 1'b1;
                                state_d   = ST_FIN;
                            end else begin
                                acc_d   = a;
                                base_d  = b;
                                cnt_d   = CW'(WIDTH);
                                state_d = ST_DIV;
                            end
                        end
                        ALU_POW: begin
                            acc_d   = WIDTH'(1);
                            base_d  = a;
                            e_d     = b;
                            state_d = ST_POW_STEP;
                        end
                        default: begin
                            acc_d      = '0;
                            pend_ill_d = 1'b1;
                            state_d    = ST_FIN;
                        end
                    endcase
                end
            end
            ST_MUL: begin
                if (mdone) begin
                    result_d    = mprod;
                    remainder_d = '0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (!div_diff[WIDTH]) begin
                    part_d = div_diff[WIDTH-1:0];
                    acc_d  = {acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    part_d = div_r[WIDTH-1:0];
                    acc_d  = {acc_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_FIN;
                end
            end
            ST_POW_STEP: begin
                if (e_q == '0) begin
                    state_d = ST_FIN;
                end else if (e_q[0]) begin
                    mstart  = 1'b1;
                    mul_a   = acc_q;
                    mul_b   = base_q;
                    state_d = ST_POW_MR;
                end else begin
                    mstart  = 1'b1;
                    mul_a   = base_q;
                    mul_b   = base_q;
                    state_d = ST_POW_SQ;
                end
            end
            ST_POW_MR: begin
                if (mdone) begin
                    acc_d   = mprod;
                    mstart  = 1'b1;
                    mul_a   = base_q;
                    mul_b   = base_q;
                    state_d = ST_POW_SQ;
                end
            end
            ST_POW_SQ: begin
                if (mdone) begin
                    base_d  = mprod;
                    e_d     = e_q >> 1;
                    state_d = ST_POW_STEP;
                end
            end
            ST_FIN: begin
                result_d      = acc_q;
                remainder_d   = part_q;
                div_by_zero_d = pend_dz_q;
                illegal_op_d  = pend_ill_q;
                done_d        = 1'b1;
                busy_d        = 1'b0;
                state_d       = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            result_q      <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            illegal_op_q  <= 1'b0;
            acc_q         <= '0;
            base_q        <= '0;
            e_q           <= '0;
            part_q        <= '0;
            cnt_q         <= '0;
            pend_dz_q     <= 1'b0;
            pend_ill_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            result_q      <= result_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            illegal_op_q  <= illegal_op_d;
            acc_q         <= acc_d;
            base_q        <= base_d;
            e_q           <= e_d;
            part_q        <= part_d;
            cnt_q         <= cnt_d;
            pend_dz_q     <= pend_dz_d;
            pend_ill_q    <= pend_ill_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
    assign illegal_op  = illegal_op_q;

endmodule

// File: tb/tb_iter_alu_unit.sv
// Scoreboard bench for iter_alu_unit: stimulus pushes expected responses,
// a negedge monitor pops and compares on every done pulse.
module tb_iter_alu_unit;
    import alu_pkg::*;

    typedef struct {
        int          id;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] rem;
        logic        dz;
        logic        ill;
        int          lo;
        int          hi;
        int          acc_cyc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        illegal_op;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   outstanding = 0;
    exp_t sb[$];
    exp_t vec[$];

    iter_alu_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .illegal_op  (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    function automatic exp_t mk(input int id, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] res, input logic [31:0] rem, input logic dz,
                                input logic ill, input int lo, input int hi);
        exp_t e;
        e.id = id; e.op = o; e.a = x; e.b = y; e.res = res; e.rem = rem;
        e.dz = dz; e.ill = ill; e.lo = lo; e.hi = hi; e.acc_cyc = 0;
        return e;
    endfunction

    // Drives start now; the following posedge is the accept edge.
    task automatic drive_accept(input exp_t e, input bit push);
        exp_t t;
        t = e;
        start = 1'b1; op = e.op; a = e.a; b = e.b;
        @(posedge clk);
        t.acc_cyc = cyc + 1;
        if (push) sb.push_back(t);
        outstanding++;
        #1 start = 1'b0;
    endtask

    task automatic issue(input exp_t e, input bit push);
        @(negedge clk);
        drive_accept(e, push);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600 && outstanding != 0; i++) @(negedge clk);
        if (outstanding != 0) begin
            checks++; errors++;
            $display("FAIL timeout_idle outstanding=%0d required=0", outstanding);
            sb.delete();
            outstanding = 0;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (reset) begin
            chk("busy", 32'(busy), 32'((outstanding != 0) && !done));
            if (done) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    lat = cyc - e.acc_cyc;
                    chk($sformatf("result[%0d]", e.id), result, e.res);
                    chk($sformatf("remainder[%0d]", e.id), remainder, e.rem);
                    chk($sformatf("div_by_zero[%0d]", e.id), 32'(div_by_zero), 32'(e.dz));
                    chk($sformatf("illegal_op[%0d]", e.id), 32'(illegal_op), 32'(e.ill));
                    checks++;
                    if (lat < e.lo || lat > e.hi) begin
                        errors++;
                        $display("FAIL latency[%0d] actual=%0d required=%0d..%0d", e.id, lat, e.lo, e.hi);
                    end
                end
                if (outstanding > 0) outstanding--;
            end
        end
    end

    initial begin
        reset = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;

        // expected values hand-computed for WIDTH=32
        vec.push_back(mk(0,  ALU_MUL, 32'd7,          32'd6,  32'd42,         32'd0, 1'b0, 1'b0, 33, 33));
        vec.push_back(mk(1,  ALU_MUL, 32'hFFFF_FFFF,  32'd2,  32'hFFFF_FFFE,  32'd0, 1'b0, 1'b0, 33, 33));
        vec.push_back(mk(2,  ALU_MUL, 32'd12345,      32'd0,  32'd0,          32'd0, 1'b0, 1'b0, 33, 33));
        vec.push_back(mk(3,  ALU_DIV, 32'd100,        32'd7,  32'd14,         32'd2, 1'b0, 1'b0, 33, 33));
        vec.push_back(mk(4,  ALU_DIV, 32'd5,          32'd0,  32'hFFFF_FFFF,  32'd5, 1'b1, 1'b0, 1, 1));
        vec.push_back(mk(5,  ALU_DIV, 32'd7,          32'd100, 32'd0,         32'd7, 1'b0, 1'b0, 33, 33));
        vec.push_back(mk(6,  ALU_DIV, 32'hFFFF_FFFF,  32'd1,  32'hFFFF_FFFF,  32'd0, 1'b0, 1'b0, 33, 33));
        vec.push_back(mk(7,  ALU_POW, 32'd3,          32'd5,  32'd243,        32'd0, 1'b0, 1'b0, 1, 200));
        vec.push_back(mk(8,  ALU_POW, 32'd2,          32'd0,  32'd1,          32'd0, 1'b0, 1'b0, 2, 2));
        vec.push_back(mk(9,  ALU_POW, 32'd2,          32'd33, 32'd0,          32'd0, 1'b0, 1'b0, 1, 398));
        vec.push_back(mk(10, ALU_POW, 32'd0,          32'd4,  32'd0,          32'd0, 1'b0, 1'b0, 1, 200));
        vec.push_back(mk(11, ALU_SUB, 32'd9,          32'd3,  32'd0,          32'd0, 1'b0, 1'b1, 1, 1));
        vec.push_back(mk(12, 3'b111,  32'd1,          32'd1,  32'd0,          32'd0, 1'b0, 1'b1, 1, 1));

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_remainder", remainder, 32'd0);
        chk("reset_div_by_zero", 32'(div_by_zero), 32'd0);
        chk("reset_illegal_op", 32'(illegal_op), 32'd0);
        @(negedge clk) reset = 1'b1;

        foreach (vec[i]) begin
            issue(vec[i], 1'b1);
            wait_idle();
        end

        // DIV request at cycle 10 of a MUL must be dropped
        issue(mk(20, ALU_MUL, 32'd7, 32'd6, 32'd42, 32'd0, 1'b0, 1'b0, 33, 33), 1'b1);
        repeat (9) @(posedge clk);
        #1 start = 1'b1; op = ALU_DIV; a = 32'd9; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();
        repeat (40) @(posedge clk);

        // back-to-back: second start driven in the done cycle of the first
        issue(mk(21, ALU_MUL, 32'd5, 32'd9, 32'd45, 32'd0, 1'b0, 1'b0, 33, 33), 1'b1);
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout_b2b_done actual=0 required=1");
        end
        drive_accept(mk(22, ALU_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33, 33), 1'b1);
        wait_idle();

        // reset at cycle 12 of a DIV: no done, outputs back to zero
        issue(mk(23, ALU_DIV, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0, 33, 33), 1'b0);
        repeat (11) @(posedge clk);
        #2 reset = 1'b0; outstanding = 0;
        #1;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_result", result, 32'd0);
        chk("midreset_remainder", remainder, 32'd0);
        chk("midreset_div_by_zero", 32'(div_by_zero), 32'd0);
        chk("midreset_illegal_op", 32'(illegal_op), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (40) @(posedge clk);
        issue(mk(24, ALU_MUL, 32'd3, 32'd4, 32'd12, 32'd0, 1'b0, 1'b0, 33, 33), 1'b1);
        wait_idle();
        repeat (5) @(posedge clk);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
